// File: rtl/sift_ori_pkg.sv
// Shared constants and state type for the SIFT orientation-assignment stages.
package sift_ori_pkg;

    localparam int NBINS = 36;
    localparam int OFS_W = 5;
    localparam int MAG_W = 12;
    localparam int ACC_W = 16;
    localparam int BIN_W = 6;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DONE  = 2'd2
    } ori_state_t;

endpackage

// File: rtl/ori_bin_wrap.sv
// Combinational base + signed offset, wrapped into 0..NBINS-1.
// The sum spans -16..50, so one conditional add or subtract of NBINS is enough.
module ori_bin_wrap
    import sift_ori_pkg::*;
(
    input  logic [BIN_W-1:0] base,
    input  logic [OFS_W-1:0] ofs,
    output logic [BIN_W-1:0] bin
);

    localparam int SUM_W = BIN_W + 2;
    localparam logic signed [SUM_W-1:0] NB_S = SUM_W'(NBINS);

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] wrapped;

    // Sign-extend the offset, add it to the base, then fold back into range.
    always_comb begin
        sum = $signed({2'b00, base}) + $signed({{(SUM_W - OFS_W){ofs[OFS_W-1]}}, ofs});
        wrapped = sum;
        if (sum[SUM_W-1]) begin
            wrapped = sum + NB_S;
        end else if (sum >= NB_S) begin
            wrapped = sum - NB_S;
        end
        bin = wrapped[BIN_W-1:0];
    end

endmodule

// File: rtl/ori_hist_acc.sv
// Orientation histogram accumulator: bins gradient magnitudes per keypoint
// window, then scans for the dominant bin and holds it until consumed.
module ori_hist_acc
    import sift_ori_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [BIN_W-1:0] in_base,
    input  logic [OFS_W-1:0] in_ofs,
    input  logic [MAG_W-1:0] in_mag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [BIN_W-1:0] res_bin,
    output logic [ACC_W-1:0] res_mag
);

    logic [ACC_W-1:0] hist_reg [NBINS];

    ori_state_t       state_reg;
    logic [BIN_W-1:0] scan_idx_reg;
    logic [BIN_W-1:0] best_bin_reg;
    logic [ACC_W-1:0] best_mag_reg;
    logic [BIN_W-1:0] res_bin_reg;
    logic [ACC_W-1:0] res_mag_reg;
    logic             res_valid_reg;
    logic             in_ready_reg;

    logic [BIN_W-1:0] wr_bin;
    logic [ACC_W-1:0] wr_cur;
    logic [ACC_W:0]   wr_sum;
    logic [ACC_W-1:0] wr_sat;
    logic [ACC_W-1:0] scan_val;
    logic             accept;
    logic             res_fire;

    ori_bin_wrap u_wrap (
        .base (in_base),
        .ofs  (in_ofs),
        .bin  (wr_bin)
    );

    assign accept   = in_valid & in_ready_reg;
    assign res_fire = res_valid_reg & res_ready;

    // Read-modify-write value for the addressed bin, saturating at all-ones.
    always_comb begin
        wr_cur   = hist_reg[wr_bin];
        wr_sum   = {1'b0, wr_cur} + {{(ACC_W + 1 - MAG_W){1'b0}}, in_mag};
        wr_sat   = wr_sum[ACC_W] ? {ACC_W{1'b1}} : wr_sum[ACC_W-1:0];
        scan_val = hist_reg[scan_idx_reg];
    end

    // One register per bin: cleared on reset or result handshake, updated on accept.
    // Reading the current register each cycle makes back-to-back hits hazard-free.
    genvar gi;
    generate
        for (gi = 0; gi < NBINS; gi++) begin : g_bin
            always_ff @(posedge clk) begin
                if (rst || res_fire) begin
                    hist_reg[gi] <= '0;
                end else if (accept && (wr_bin == BIN_W'(gi))) begin
                    hist_reg[gi] <= wr_sat;
                end
            end
        end
    endgenerate

    // Control FSM: accumulate, scan one bin per cycle, then present the result.
    // DONE spends its first cycle latching the final best into the output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_ACCUM;
            scan_idx_reg  <= '0;
            best_bin_reg  <= '0;
            best_mag_reg  <= '0;
            res_bin_reg   <= '0;
            res_mag_reg   <= '0;
            res_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_ACCUM: begin
                    if (accept && in_last) begin
                        state_reg    <= ST_SCAN;
                        scan_idx_reg <= '0;
                        best_bin_reg <= '0;
                        best_mag_reg <= '0;
                        in_ready_reg <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (scan_val > best_mag_reg) begin
                        best_bin_reg <= scan_idx_reg;
                        best_mag_reg <= scan_val;
                    end
                    if (scan_idx_reg == BIN_W'(NBINS - 1)) begin
                        state_reg <= ST_DONE;
                    end else begin
                        scan_idx_reg <= scan_idx_reg + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!res_valid_reg) begin
                        res_bin_reg   <= best_bin_reg;
                        res_mag_reg   <= best_mag_reg;
                        res_valid_reg <= 1'b1;
                    end else if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_ACCUM;
                    end
                end
                default: begin
                    state_reg    <= ST_ACCUM;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign res_valid = res_valid_reg;
    assign res_bin   = res_bin_reg;
    assign res_mag   = res_mag_reg;

endmodule

// File: tb/tb_ori_hist_acc.sv
// Self-checking bench for ori_hist_acc: directed window table, hand-written
// corner sequences, and randomized windows against a plain-integer histogram model.
module tb_ori_hist_acc;
    import sift_ori_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [BIN_W-1:0] in_base;
    logic [OFS_W-1:0] in_ofs;
    logic [MAG_W-1:0] in_mag;
    logic             res_valid;
    logic             res_ready;
    logic [BIN_W-1:0] res_bin;
    logic [ACC_W-1:0] res_mag;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural histogram model
    int mh [NBINS];

    always #5 clk = ~clk;

    ori_hist_acc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_base   (in_base),
        .in_ofs    (in_ofs),
        .in_mag    (in_mag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_bin   (res_bin),
        .res_mag   (res_mag)
    );

    typedef struct {
        int               n;
        logic [3:0][5:0]  base;
        logic [3:0][4:0]  ofs;
        logic [3:0][11:0] mag;
        int               exp_bin;
        int               exp_mag;
    } win_t;

    win_t tbl [4];

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NBINS; i++) mh[i] = 0;
    endfunction

    function automatic void model_add(input int base, input logic [4:0] ofs, input int mag);
        int b;
        b = (((base + int'($signed(ofs))) % NBINS) + NBINS) % NBINS;
        mh[b] = mh[b] + mag;
        if (mh[b] > 65535) mh[b] = 65535;
    endfunction

    function automatic void model_best(output int bb, output int bm);
        bb = 0;
        bm = 0;
        for (int i = 0; i < NBINS; i++) begin
            if (mh[i] > bm) begin
                bb = i;
                bm = mh[i];
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until it is accepted (bounded wait).
    task automatic send(input int base, input logic [4:0] ofs, input int mag, input bit last);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!in_ready) check("send_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_base  = 6'(base);
        in_ofs   = ofs;
        in_mag   = 12'(mag);
        in_last  = last;
        model_add(base, ofs, mag);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for the result, checking latency and that no sample is taken meanwhile.
    // Junk samples are driven while in_ready is low; they must be ignored.
    task automatic collect(output int b, output int m, input bit do_ack);
        int k = 0;
        bit rdy_seen = 0;
        while (!res_valid && k < 100) begin
            if (in_ready) rdy_seen = 1;
            in_valid = 1'b1;
            in_base  = 6'($urandom_range(0, NBINS - 1));
            in_ofs   = 5'($urandom);
            in_mag   = 12'hfff;
            in_last  = 1'($urandom);
            tick();
            k++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("latency", k, NBINS + 1);
        check("in_ready_low_while_busy", rdy_seen, 0);
        b = res_bin;
        m = res_mag;
        if (do_ack) begin
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            check("res_valid_drop", res_valid, 0);
            check("in_ready_back", in_ready, 1);
            model_clear();
        end
    endtask

    initial begin
        int b, m, eb, em, n;
        int hb, hm;
        bit stable;

        tbl[0] = '{n: 1, base: {6'd0, 6'd0, 6'd0, 6'd0}, ofs: {5'h0, 5'h0, 5'h0, 5'h1a},
                   mag: {12'd0, 12'd0, 12'd0, 12'd100}, exp_bin: 30, exp_mag: 100};
        tbl[1] = '{n: 2, base: {6'd0, 6'd0, 6'd3, 6'd35}, ofs: {5'h0, 5'h0, 5'h00, 5'h09},
                   mag: {12'd0, 12'd0, 12'd5, 12'd7}, exp_bin: 8, exp_mag: 7};
        tbl[2] = '{n: 2, base: {6'd0, 6'd0, 6'd24, 6'd4}, ofs: {5'h0, 5'h0, 5'h1c, 5'h01},
                   mag: {12'd0, 12'd0, 12'd300, 12'd300}, exp_bin: 5, exp_mag: 300};
        tbl[3] = '{n: 3, base: {6'd0, 6'd30, 6'd2, 6'd1}, ofs: {5'h0, 5'h0f, 5'h00, 5'h10},
                   mag: {12'd0, 12'd59, 12'd60, 12'd50}, exp_bin: 2, exp_mag: 60};

        in_valid = 0; in_last = 0; in_base = 0; in_ofs = 0; in_mag = 0; res_ready = 0;
        rst = 1'b1;
        model_clear();
        tick(); tick();
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_res_valid", res_valid, 0);
        check("reset_res_bin", res_bin, 0);
        check("reset_res_mag", res_mag, 0);

        // Directed windows from the table
        for (int t = 0; t < 4; t++) begin
            for (int s = 0; s < tbl[t].n; s++)
                send(int'(tbl[t].base[s]), tbl[t].ofs[s], int'(tbl[t].mag[s]), s == tbl[t].n - 1);
            collect(b, m, 1'b1);
            check($sformatf("tbl%0d_bin", t), b, tbl[t].exp_bin);
            check($sformatf("tbl%0d_mag", t), m, tbl[t].exp_mag);
            $display("window tbl%0d: bin=%0d mag=%0d", t, b, m);
        end

        // Saturation: back-to-back hits on bin 12, 20 x 4095 total
        for (int s = 0; s < 20; s++)
            send((s % 2) ? 10 : 12, (s % 2) ? 5'h02 : 5'h00, 4095, s == 19);
        collect(b, m, 1'b0);
        check("sat_bin", b, 12);
        check("sat_mag", m, 16'hffff);
        $display("window sat: bin=%0d mag=%0d", b, m);

        // Backpressure: result must hold while res_ready stays low
        stable = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!res_valid || res_bin != 6'd12 || res_mag != 16'hffff) stable = 0;
        end
        check("hold_stable", stable, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        model_clear();
        check("hold_release", res_valid, 0);
        send(2, 5'h00, 9, 1'b1);
        collect(b, m, 1'b1);
        check("clear_bin", b, 2);
        check("clear_mag", m, 9);
        $display("window clear: bin=%0d mag=%0d", b, m);

        // Reset in the middle of a scan
        send(7, 5'h00, 44, 1'b1);
        for (int c = 0; c < 10; c++) tick();
        check("midscan_busy", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check("midscan_rst_in_ready", in_ready, 1);
        check("midscan_rst_res_valid", res_valid, 0);
        send(0, 5'h00, 1, 1'b1);
        collect(b, m, 1'b1);
        check("post_rst_bin", b, 0);
        check("post_rst_mag", m, 1);
        $display("window post_rst: bin=%0d mag=%0d", b, m);

        // Randomized windows against the model
        for (int w = 0; w < 25; w++) begin
            n = $urandom_range(1, 40);
            hb = $urandom_range(0, NBINS - 1);
            for (int s = 0; s < n; s++) begin
                repeat ($urandom_range(0, 2)) tick();
                if ($urandom_range(0, 3) == 0)
                    send(hb, 5'h00, $urandom_range(2000, 4095), s == n - 1);
                else
                    send($urandom_range(0, NBINS - 1), 5'($urandom), $urandom_range(0, 4095), s == n - 1);
            end
            model_best(eb, em);
            collect(b, m, 1'b0);
            repeat ($urandom_range(0, 3)) begin
                tick();
                if (res_bin != 6'(b) || res_mag != 16'(m)) check("rand_hold", 0, 1);
            end
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            model_clear();
            check($sformatf("rand%0d_bin", w), b, eb);
            check($sformatf("rand%0d_mag", w), m, em);
            $display("window rand%0d: n=%0d bin=%0d mag=%0d", w, n, b, m);
        end

        // All-zero histogram
        send(17, 5'h00, 0, 1'b1);
        collect(b, m, 1'b1);
        check("zero_bin", b, 0);
        check("zero_mag", m, 0);
        $display("window zero: bin=%0d mag=%0d", b, m);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ori_hist_acc.md
Name: ori_hist_acc

Overview:
- Orientation histogram accumulator for SIFT keypoint orientation assignment. It sits directly downstream of the distributed direction ROMs (dir8_*).
- Each gradient sample arrives as a 6-bit base bin plus the ROM's 5-bit signed offset, together with a gradient magnitude. The block wraps base plus offset into the range 0..NBINS-1 and accumulates the magnitude into that bin.
- On the last sample of a keypoint window, it scans the histogram and returns the dominant bin and its peak value.

Parameters:
- NBINS, 36, number of orientation bins; values wrap modulo NBINS.
- OFS_W, 5, width of the signed direction offset from the ROM.
- MAG_W, 12, width of the unsigned gradient magnitude.
- ACC_W, 16, width of each bin accumulator; accumulators saturate.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- in_last  in  1  final sample of the keypoint window.
- in_base  in  6  base bin, 0..NBINS-1.
- in_ofs  in  OFS_W  signed bin offset (two's complement).
- in_mag  in  MAG_W  unsigned gradient magnitude.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_bin  out  6  dominant bin index.
- res_mag  out  ACC_W  accumulated value of the dominant bin.

Behaviour:
- Reset: all bins 0, state ACCUM, in_ready=1, res_valid=0, res_bin=0, res_mag=0. Reset has priority in every state, including mid-SCAN and DONE.
- States: ACCUM, SCAN, DONE.
- Bin computation (combinational): s = in_base + sign-extend(in_ofs), range -16..50.
  - s<0: bin = s+NBINS.
  - s>=NBINS: bin = s-NBINS.
  - otherwise: bin = s.
  - Behaviour for in_base >= NBINS is undefined; the bench does not drive it.
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready: hist[bin] <= min(hist[bin]+in_mag, 2^ACC_W-1) at the same edge.
  - Back-to-back samples to the same bin must accumulate correctly (single-cycle read-modify-write, no hazard).
  - Accept with in_last=1: the sample is accumulated, then go to SCAN with scan index 0, best_bin=0, best_mag=0.
- SCAN:
  - in_ready=0.
  - One bin per cycle, indices 0..NBINS-1.
  - Update the best only when hist[i] > best_mag (strictly greater), so ties resolve to the lowest index.
  - After index NBINS-1 is compared, go to DONE.
  - SCAN lasts exactly NBINS cycles.
- DONE:
  - res_valid=1; res_bin and res_mag hold the best values and stay stable while res_ready=0.
  - On res_valid&res_ready: all bins clear to 0 at that edge, res_valid drops, go to ACCUM.
- Latency: last sample accepted at edge E → res_valid high from edge E+NBINS+1 (37 cycles for NBINS=36).
- An all-zero histogram yields res_bin=0, res_mag=0.
- An empty window is impossible because in_last always accompanies a sample.
- in_valid while in_ready=0 is ignored; the upstream holds the sample.

Decomposition:
- Shared package sift_ori_pkg:
  - NBINS, OFS_W, MAG_W, ACC_W constants.
  - State enum (ACCUM/SCAN/DONE).
  - BIN_W=6.
- Sub-module ori_bin_wrap: combinational base+offset modulo-NBINS wrap. It is reused by the later peak-interpolation stage.
- Histogram is a register array; no block RAM, so the clear is single-cycle.

Test Plan:
- Single-sample window: base=0, ofs=5'h1a (-6), mag=100, last=1 → after 37 cycles res_valid=1, res_bin=30, res_mag=100; in_ready=0 throughout SCAN/DONE.
- Wrap high: base=35, ofs=5'h09, mag=7, then base=3, ofs=5'h00, mag=5 (last) → res_bin=8, res_mag=7.
- Same-bin back-to-back: three consecutive samples to bin 12, mag 4095 each, plus 17 more → accumulator saturates at 16'hFFFF, res_bin=12, res_mag=16'hFFFF.
- Tie: bins 5 and 20 each receive 300 → res_bin=5, res_mag=300.
- Backpressure and clear:
  - Hold res_ready=0 for 10 cycles → res_valid, res_bin and res_mag stay constant.
  - Then assert res_ready and send a new window hitting bin 2 only with mag=9 → res_bin=2, res_mag=9, proving the old bins were cleared.
- Reset mid-SCAN: assert rst for 1 cycle at scan index 10 → next cycle in_ready=1, res_valid=0. A following window with bin 0, mag=1 → res_bin=0, res_mag=1.
